multicycle_ctrl: RTL and testbench

//  Multicycle RV32I control FSM. Sequences the shared ALU, instruction/data memory port, PC and register file.

---
 rtl/riscv_pkg.sv | 79 +++++++
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/multicycle_ctrl_alu_decoder.sv | 35 +++
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg : shared RV32I types for the multicycle control path   (rev 1.0)
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6
  } alu_ops_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } ctrl_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REG   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011
  } imm_src_t;

  // Immediate format is a pure function of the opcode; unknown opcodes fall back to I.
  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_ctrl_if : control <-> datapath/memory signal bundle   (rev 1.0)
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
  import riscv_pkg::*;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;

  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  imm_src_t    imm_src;
  alu_src_a_t  alu_src_a;
  alu_src_b_t  alu_src_b;
  result_src_t result_src;
  alu_ops_t    alu_ctrl;
  logic        trap;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    output imm_src, alu_src_a, alu_src_b, result_src, alu_ctrl, trap
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    input  imm_src, alu_src_a, alu_src_b, result_src, alu_ctrl, trap
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_decoder : funct3/funct7b5 -> ALU operation, flags shift forms   (rev 1.0)
// ----------------------------------------------------------------------------
module alu_decoder
  import riscv_pkg::*;
(
  input  wire logic [6:0] op,
  input  wire logic [2:0] funct3,
  input  wire logic       funct7b5,
  output alu_ops_t        alu_op,
  output logic            illegal_alu
);

  logic is_rtype;

  assign is_rtype = (op == OP_R);

  always_comb begin
    alu_op      = ALU_ADD;
    illegal_alu = 1'b0;
    case (funct3)
      // funct7b5 only selects SUB for register-register ops; in I-type it is immediate data
      3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: illegal_alu = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_ctrl : RV32I multicycle control FSM with memory timeout   (rev 1.0)
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)
(
  input  wire logic         clk,
  input  wire logic         rst,
  multicycle_ctrl_if.master bus
);

  localparam int               CNT_W    = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  ctrl_state_t      decode_next;
  logic [CNT_W-1:0] wait_cnt;

  alu_ops_t         dec_op;
  logic             illegal_alu;
  logic             mem_state;
  logic             timed_out;

  logic             mem_req;
  logic             mem_we;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  alu_src_a_t       src_a;
  alu_src_b_t       src_b;
  result_src_t      result_src;
  alu_ops_t         alu_ctrl;

  alu_decoder u_alu_decoder (
    .op          (bus.op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .alu_op      (dec_op),
    .illegal_alu (illegal_alu)
  );

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timed_out = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Any state change clears the count, so every FETCH/MEMREAD/MEMWRITE entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (mem_state && !bus.mem_ready && (MEM_TIMEOUT != 0)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    decode_next = S_TRAP;
    case (bus.op)
      OP_R:              if (!illegal_alu) decode_next = S_EXECR;
      OP_I:              if (!illegal_alu) decode_next = S_EXECI;
      OP_LOAD, OP_STORE: if (bus.funct3 == F3_WORD) decode_next = S_MEMADR;
      OP_BRANCH:         if ((bus.funct3 == F3_BEQ) || (bus.funct3 == F3_BNE)) decode_next = S_BRANCH;
      OP_JAL:            decode_next = S_JAL;
      default:           decode_next = S_TRAP;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    src_a      = SRCA_PC;
    src_b      = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_ctrl   = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          src_a      = SRCA_PC;
          src_b      = SRCB_FOUR;
          result_src = RES_ALU;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        // Branch/jal target is computed here and parked in ALUOut
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_IMM;
        state_next = decode_next;
      end
      S_MEMADR: begin
        src_a      = SRCA_REG;
        src_b      = SRCB_IMM;
        state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_MEMWB;
        end else if (timed_out) begin
          state_next = S_TRAP;
        end
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_FETCH;
        end else if (timed_out) begin
          state_next = S_TRAP;
        end
      end
      S_EXECR: begin
        src_a      = SRCA_REG;
        src_b      = SRCB_REG;
        alu_ctrl   = dec_op;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        src_a      = SRCA_REG;
        src_b      = SRCB_IMM;
        alu_ctrl   = dec_op;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        src_a      = SRCA_REG;
        src_b      = SRCB_REG;
        alu_ctrl   = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = (bus.funct3 == F3_BNE) ? !bus.zero : bus.zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value OldPC+4
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase

    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.imm_src    = imm_src_of(bus.op);
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.result_src = result_src;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.trap       = (state == S_TRAP);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_multicycle_ctrl : per-cycle control vectors queued by instruction models, compared at negedge.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  localparam int TMO = 16;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_ILL} kind_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       trap;
  } vec_t;

  localparam vec_t MALL = '1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] cur_imm = 3'b000;

  vec_t  exp_q[$];
  vec_t  mask_q[$];
  string tag_q[$];
  vec_t  obs;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus0 ();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut  (.clk(clk), .rst(rst), .bus(bus));
  multicycle_ctrl #(.MEM_TIMEOUT(0))   dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  assign obs = {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl, bus.imm_src, bus.trap};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t  e;
      vec_t  m;
      string t;
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s: got %h expected %h (mask %h) at %0t", t, obs & m, e & m, m, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      7'h23:   return 3'b001;
      7'h63:   return 3'b010;
      7'h6F:   return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v     = '0;
    v.alu = ALU_ADD;
    v.imm = cur_imm;
    return v;
  endfunction

  function automatic vec_t mask_en(input logic with_trap);
    vec_t m;
    m           = '0;
    m.mem_req   = 1'b1;
    m.mem_we    = 1'b1;
    m.ir_write  = 1'b1;
    m.pc_write  = 1'b1;
    m.reg_write = 1'b1;
    m.trap      = with_trap;
    return m;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic r, input logic rdy, input logic z, input vec_t e, input vec_t m, input string t);
    rst           = r;
    bus.mem_ready = rdy;
    bus.zero      = z;
    exp_q.push_back(e);
    mask_q.push_back(m);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] instr);
    bus.op       = instr[6:0];
    bus.funct3   = instr[14:12];
    bus.funct7b5 = instr[30];
    cur_imm      = imm_for(instr[6:0]);
  endtask

  task automatic trap_cycles(input string t, input int n);
    vec_t v;
    v      = blank();
    v.trap = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, rnd(), rnd(), v, MALL, {t, " trap"});
  endtask

  task automatic do_reset(input int n, input logic from_trap);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, blank(), mask_en(!from_trap), "reset");
  endtask

  task automatic wait_phase(input vec_t v, input int waits, input logic z, input string t, output bit trapped);
    int n;
    n = (waits < TMO) ? waits : TMO;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, z, v, MALL, {t, "-wait"});
    trapped = (waits >= TMO);
    if (trapped) trap_cycles(t, 3);
  endtask

  task automatic run_instr(input string name, input logic [31:0] instr, input kind_t k,
                           input alu_ops_t alu_exp, input logic z, input int fetch_wait, input int mem_wait);
    vec_t v;
    bit   trapped;
    set_instr(instr);
    v         = blank();
    v.mem_req = 1'b1;
    wait_phase(v, fetch_wait, z, {name, " fetch"}, trapped);
    if (trapped) return;
    v.ir_write = 1'b1;
    v.pc_write = 1'b1;
    v.src_b    = 2'b10;
    v.res      = 2'b10;
    cyc(1'b0, 1'b1, z, v, MALL, {name, " fetch"});
    v       = blank();
    v.src_a = 2'b01;
    v.src_b = 2'b01;
    cyc(1'b0, rnd(), z, v, MALL, {name, " decode"});
    case (k)
      K_ILL: begin
        trap_cycles(name, 3);
        return;
      end
      K_R, K_I: begin
        v       = blank();
        v.src_a = 2'b10;
        v.src_b = (k == K_R) ? 2'b00 : 2'b01;
        v.alu   = alu_exp;
        cyc(1'b0, rnd(), z, v, MALL, {name, " exec"});
      end
      K_LW, K_SW: begin
        v       = blank();
        v.src_a = 2'b10;
        v.src_b = 2'b01;
        cyc(1'b0, rnd(), z, v, MALL, {name, " memadr"});
        v         = blank();
        v.mem_req = 1'b1;
        v.adr_src = 1'b1;
        v.mem_we  = (k == K_SW);
        wait_phase(v, mem_wait, z, {name, " mem"}, trapped);
        if (trapped) return;
        cyc(1'b0, 1'b1, z, v, MALL, {name, " mem"});
        if (k == K_SW) return;
        v           = blank();
        v.res       = 2'b01;
        v.reg_write = 1'b1;
        cyc(1'b0, rnd(), z, v, MALL, {name, " memwb"});
        return;
      end
      K_BEQ, K_BNE: begin
        v          = blank();
        v.src_a    = 2'b10;
        v.src_b    = 2'b00;
        v.alu      = ALU_SUB;
        v.pc_write = (k == K_BEQ) ? z : !z;
        cyc(1'b0, rnd(), z, v, MALL, {name, " branch"});
        return;
      end
      K_JAL: begin
        v          = blank();
        v.src_a    = 2'b01;
        v.src_b    = 2'b10;
        v.pc_write = 1'b1;
        cyc(1'b0, rnd(), z, v, MALL, {name, " jal"});
      end
      default: ;
    endcase
    v           = blank();
    v.reg_write = 1'b1;
    cyc(1'b0, rnd(), z, v, MALL, {name, " aluwb"});
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.trap} !== 6'b0) begin
      errors++;
      $display("FAIL reset_enables: got %b expected 000000",
               {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.trap});
    end
    @(posedge clk);
    #1;
    do_reset(2, 1'b0);
  endtask

  task automatic test_alu();
    run_instr("add",   32'h002081B3, K_R, ALU_ADD,  1'b0, 0, 0);
    run_instr("sub",   32'h402081B3, K_R, ALU_SUB,  1'b0, 0, 0);
    run_instr("xor",   32'h0020C1B3, K_R, ALU_XOR,  1'b0, 1, 0);
    run_instr("or",    32'h0020E1B3, K_R, ALU_OR,   1'b0, 0, 0);
    run_instr("and",   32'h0020F1B3, K_R, ALU_AND,  1'b0, 0, 0);
    run_instr("slt",   32'h0020A1B3, K_R, ALU_SLT,  1'b0, 0, 0);
    run_instr("sltu",  32'h0020B1B3, K_R, ALU_SLTU, 1'b0, 0, 0);
    run_instr("addi",  32'h00508093, K_I, ALU_ADD,  1'b0, 0, 0);
    run_instr("addi30",32'h40008093, K_I, ALU_ADD,  1'b0, 0, 0);
    run_instr("slti",  32'h0050A093, K_I, ALU_SLT,  1'b0, 0, 0);
    run_instr("sltiu", 32'h0050B093, K_I, ALU_SLTU, 1'b0, 0, 0);
    run_instr("xori30",32'h4050C093, K_I, ALU_XOR,  1'b0, 0, 0);
    run_instr("andi",  32'h0050F093, K_I, ALU_AND,  1'b0, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("lw0",  32'h0000A183, K_LW, ALU_ADD, 1'b0, 0, 0);
    run_instr("lw3",  32'h0000A183, K_LW, ALU_ADD, 1'b0, 0, 3);
    run_instr("sw0",  32'h0020A023, K_SW, ALU_ADD, 1'b0, 0, 0);
    run_instr("sw10", 32'h0020A023, K_SW, ALU_ADD, 1'b0, 0, 10);
    run_instr("add15",32'h002081B3, K_R,  ALU_ADD, 1'b0, 15, 0);
  endtask

  task automatic test_branch_jal();
    run_instr("beq_z1", 32'h00208063, K_BEQ, ALU_SUB, 1'b1, 0, 0);
    run_instr("beq_z0", 32'h00208063, K_BEQ, ALU_SUB, 1'b0, 0, 0);
    run_instr("bne_z1", 32'h00209063, K_BNE, ALU_SUB, 1'b1, 0, 0);
    run_instr("bne_z0", 32'h00209063, K_BNE, ALU_SUB, 1'b0, 0, 0);
    run_instr("jal",    32'h008000EF, K_JAL, ALU_ADD, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_memread();
    vec_t v;
    set_instr(32'h0000A183);
    v          = blank();
    v.mem_req  = 1'b1;
    v.ir_write = 1'b1;
    v.pc_write = 1'b1;
    v.src_b    = 2'b10;
    v.res      = 2'b10;
    cyc(1'b0, 1'b1, 1'b0, v, MALL, "rmr fetch");
    v       = blank();
    v.src_a = 2'b01;
    v.src_b = 2'b01;
    cyc(1'b0, 1'b0, 1'b0, v, MALL, "rmr decode");
    v       = blank();
    v.src_a = 2'b10;
    v.src_b = 2'b01;
    cyc(1'b0, 1'b0, 1'b0, v, MALL, "rmr memadr");
    v         = blank();
    v.mem_req = 1'b1;
    v.adr_src = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, v, MALL, "rmr memread");
    cyc(1'b0, 1'b0, 1'b0, v, MALL, "rmr memread");
    cyc(1'b1, 1'b1, 1'b0, blank(), mask_en(1'b1), "rmr in-reset");
    v         = blank();
    v.mem_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, v, MALL, "rmr fetch-after");
    run_instr("rmr add", 32'h002081B3, K_R, ALU_ADD, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("ill7f", 32'h0000007F, K_ILL, ALU_ADD, 1'b0, 0, 0);
    trap_cycles("ill7f sticky", 5);
    @(negedge clk);
    checks++;
    if ({bus.trap, bus.mem_req, bus.pc_write} !== 3'b100) begin
      errors++;
      $display("FAIL trap_sticky: got trap/mem_req/pc_write %b expected 100",
               {bus.trap, bus.mem_req, bus.pc_write});
    end
    @(posedge clk);
    #1;
    do_reset(1, 1'b1);
    run_instr("sll",  32'h002091B3, K_ILL, ALU_ADD, 1'b0, 0, 0);
    do_reset(1, 1'b1);
    run_instr("slli", 32'h00109093, K_ILL, ALU_ADD, 1'b0, 0, 0);
    do_reset(1, 1'b1);
    run_instr("lb",   32'h00008183, K_ILL, ALU_ADD, 1'b0, 0, 0);
    do_reset(1, 1'b1);
    run_instr("blt",  32'h0020C063, K_ILL, ALU_ADD, 1'b0, 0, 0);
    do_reset(1, 1'b1);
    run_instr("after", 32'h002081B3, K_R, ALU_ADD, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset(1, 1'b0);
    run_instr("fetch15", 32'h002081B3, K_R,  ALU_ADD, 1'b0, 15, 0);
    run_instr("fetch16", 32'h002081B3, K_R,  ALU_ADD, 1'b0, 16, 0);
    @(negedge clk);
    checks++;
    if ((bus0.trap !== 1'b0) || (bus0.mem_req !== 1'b1)) begin
      errors++;
      $display("FAIL no_timeout_when_zero: got trap=%b mem_req=%b expected trap=0 mem_req=1",
               bus0.trap, bus0.mem_req);
    end
    @(posedge clk);
    #1;
    do_reset(1, 1'b1);
    run_instr("lw16", 32'h0000A183, K_LW, ALU_ADD, 1'b0, 0, 16);
    do_reset(1, 1'b1);
    run_instr("sw15", 32'h0020A023, K_SW, ALU_ADD, 1'b0, 0, 15);
    run_instr("sw16", 32'h0020A023, K_SW, ALU_ADD, 1'b0, 0, 16);
    do_reset(1, 1'b1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.op         = 7'b0;
    bus.funct3     = 3'b0;
    bus.funct7b5   = 1'b0;
    bus.zero       = 1'b0;
    bus.mem_ready  = 1'b0;
    bus0.op        = 7'b0110011;
    bus0.funct3    = 3'b000;
    bus0.funct7b5  = 1'b0;
    bus0.zero      = 1'b0;
    bus0.mem_ready = 1'b0;

    test_reset();
    test_alu();
    test_mem();
    test_branch_jal();
    test_reset_mid_memread();
    test_illegal();
    test_timeout();

    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
